s2p_rx: RTL and testbench

S2P_RX -- requirements
Module: s2p_rx

---
 rtl/s2p_rx_pkg.sv | 11 +
 rtl/s2p_bitcnt.sv | 30 +++
 rtl/s2p_rx.sv | 101 ++++++++++
 tb/tb_s2p_rx.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/s2p_rx_pkg.sv
// rtl/s2p_rx_pkg.sv - shared state encoding and default word width for the serial-to-parallel blocks
package s2p_rx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int S2P_DEFAULT_WIDTH = 16;

endpackage

// File: rtl/s2p_bitcnt.sv
// rtl/s2p_bitcnt.sv - bit counter with hold, clear (optionally restarting at 1) and terminal-count flag
module s2p_bitcnt
    import s2p_rx_pkg::*;
#(
    parameter int WIDTH = S2P_DEFAULT_WIDTH,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_tc
);

    logic [CW-1:0] r_cnt;

    // clr together with inc restarts the count at 1 (the current bit is bit 0 of a new word)
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= i_inc ? CW'(1) : '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tc = (r_cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/s2p_rx.sv
// rtl/s2p_rx.sv - serial-to-parallel receiver with word-sync realignment and error pulse
module s2p_rx
    import s2p_rx_pkg::*;
#(
    parameter int WIDTH     = S2P_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_S2P,
    input  logic             i_enable,
    input  logic             i_sync,
    output logic [WIDTH-1:0] o_S2P,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_err
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_word;
    logic             r_valid;
    logic             r_err;
    logic             w_clr;
    logic             w_inc;
    logic             w_tc;
    logic             w_done;
    logic             w_restart;
    logic [WIDTH-1:0] w_first;
    logic [WIDTH-1:0] w_shifted;

    s2p_bitcnt #(.WIDTH(WIDTH)) u_bitcnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_clr),
        .i_inc   (w_inc),
        .o_tc    (w_tc)
    );

    // Bit 0 enters at the end that ends up at its final position after WIDTH-1 more shifts
    assign w_first   = MSB_FIRST ? {{(WIDTH-1){1'b0}}, i_S2P} : {i_S2P, {(WIDTH-1){1'b0}}};
    assign w_shifted = MSB_FIRST ? {r_shift[WIDTH-2:0], i_S2P} : {i_S2P, r_shift[WIDTH-1:1]};

    assign w_restart = i_enable && i_sync && (r_state == SHIFT);
    assign w_done    = i_enable && !i_sync && (r_state == SHIFT) && w_tc;

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_inc       = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_enable) begin
                    w_state_nxt = SHIFT;
                    w_inc       = 1'b1;
                end
            end
            SHIFT: begin
                if (i_enable) begin
                    if (i_sync) begin
                        w_clr = 1'b1;
                        w_inc = 1'b1;
                    end else if (w_tc) begin
                        w_clr       = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_inc = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_done;
            r_err   <= w_restart;
            if (i_enable) begin
                r_shift <= (r_state == IDLE || i_sync) ? w_first : w_shifted;
            end
            if (w_done) begin
                r_word <= w_shifted;
            end
        end
    end

    assign o_S2P   = r_word;
    assign o_valid = r_valid;
    assign o_err   = r_err;
    assign o_busy  = (r_state == SHIFT);

endmodule

// File: tb/tb_s2p_rx.sv
// tb/tb_s2p_rx.sv - scoreboard bench driving MSB-first and LSB-first receivers with one bit stream
module tb_s2p_rx;

    localparam int W = 16;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         ser   = 1'b0;
    logic         en    = 1'b0;
    logic         sy    = 1'b0;
    logic [W-1:0] m_word, l_word;
    logic         m_valid, m_busy, m_err;
    logic         l_valid, l_busy, l_err;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    bit done   = 1'b0;

    typedef struct {
        bit           err;
        logic [W-1:0] vm;
        logic [W-1:0] vl;
        int           cyc;
    } ev_t;

    ev_t          q_m[$];
    ev_t          q_l[$];
    bit           bits[$];
    logic [W-1:0] last_m   = '0;
    logic [W-1:0] last_l   = '0;
    bit           exp_busy = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    s2p_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .i_clk(clk), .i_rst_n(rst_n), .i_S2P(ser), .i_enable(en), .i_sync(sy),
        .o_S2P(m_word), .o_valid(m_valid), .o_busy(m_busy), .o_err(m_err)
    );

    s2p_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .i_clk(clk), .i_rst_n(rst_n), .i_S2P(ser), .i_enable(en), .i_sync(sy),
        .o_S2P(l_word), .o_valid(l_valid), .o_busy(l_busy), .o_err(l_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: a word is just the list of accepted bits; weights are applied on completion
    task automatic step(input bit e, input bit b, input bit s, input bit r);
        ev_t ev;
        @(negedge clk);
        en = e; ser = b; sy = s; rst_n = r;
        if (!r) begin
            bits.delete();
            last_m = '0;
            last_l = '0;
        end else if (e) begin
            if (s && bits.size() > 0) begin
                ev.err = 1'b1; ev.vm = last_m; ev.vl = last_l; ev.cyc = cyc + 1;
                q_m.push_back(ev);
                q_l.push_back(ev);
                bits.delete();
            end
            bits.push_back(b);
            if (bits.size() == W) begin
                last_m = '0;
                last_l = '0;
                for (int i = 0; i < W; i++) begin
                    if (bits[i]) begin
                        last_m = last_m | (W'(1) << (W - 1 - i));
                        last_l = last_l | (W'(1) << i);
                    end
                end
                ev.err = 1'b0; ev.vm = last_m; ev.vl = last_l; ev.cyc = cyc + 1;
                q_m.push_back(ev);
                q_l.push_back(ev);
                bits.delete();
            end
        end
        exp_busy = (bits.size() > 0);
    endtask

    task automatic send_bits(input logic [W-1:0] v, input int first, input int last, input bit sync_first);
        for (int i = first; i >= last; i--) step(1'b1, v[i], (i == first) && sync_first, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        ev_t ev;
        while (!done) begin
            @(posedge clk);
            #1;
            check("m_busy", m_busy, exp_busy);
            check("l_busy", l_busy, exp_busy);
            check("m_word", m_word, last_m);
            check("l_word", l_word, last_l);
            while (q_m.size() > 0 && q_m[0].cyc < cyc) begin
                ev = q_m.pop_front();
                check("m_missed_pulse", 32'(cyc), 32'(ev.cyc));
            end
            while (q_l.size() > 0 && q_l[0].cyc < cyc) begin
                ev = q_l.pop_front();
                check("l_missed_pulse", 32'(cyc), 32'(ev.cyc));
            end
            if (m_valid || m_err) begin
                if (q_m.size() == 0) check("m_unexpected_pulse", {m_valid, m_err}, 0);
                else begin
                    ev = q_m.pop_front();
                    check("m_err", m_err, ev.err);
                    check("m_valid", m_valid, !ev.err);
                    check("m_pulse_cycle", 32'(cyc), 32'(ev.cyc));
                    if (!ev.err) check("m_valid_word", m_word, ev.vm);
                end
            end
            if (l_valid || l_err) begin
                if (q_l.size() == 0) check("l_unexpected_pulse", {l_valid, l_err}, 0);
                else begin
                    ev = q_l.pop_front();
                    check("l_err", l_err, ev.err);
                    check("l_valid", l_valid, !ev.err);
                    check("l_pulse_cycle", 32'(cyc), 32'(ev.cyc));
                    if (!ev.err) check("l_valid_word", l_word, ev.vl);
                end
            end
        end
    end

    initial begin
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        // single word straight out of reset
        send_bits(16'hCCCC, W - 1, 0, 1'b0);
        idle(2);
        // back-to-back words
        send_bits(16'hCCCC, W - 1, 0, 1'b0);
        send_bits(16'h00FF, W - 1, 0, 1'b0);
        idle(1);
        // stall mid-word
        send_bits(16'hA5A5, W - 1, 8, 1'b0);
        idle(5);
        send_bits(16'hA5A5, 7, 0, 1'b0);
        idle(1);
        // resync after a partial word
        send_bits(16'h5A3C, W - 1, 6, 1'b0);
        send_bits(16'h1234, W - 1, 0, 1'b1);
        // sync in idle is not an error
        send_bits(16'hBEEF, W - 1, 0, 1'b1);
        // sync on the completing edge wins
        send_bits(16'h7777, W - 1, 1, 1'b0);
        send_bits(16'h8001, W - 1, 0, 1'b1);
        // reset mid-word
        send_bits(16'h6B6B, W - 1, 9, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        send_bits(16'hFFFF, W - 1, 0, 1'b0);
        // single leading one: LSB-first receiver sees 0001
        send_bits(16'h8000, W - 1, 0, 1'b0);
        idle(1);
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 99) < 75, 1'($urandom), $urandom_range(0, 99) < 4,
                 $urandom_range(0, 199) != 0);
        end
        idle(3);
        done = 1'b1;
        @(posedge clk);
        #2;
        check("m_pending_events", 32'(q_m.size()), 0);
        check("l_pending_events", 32'(q_l.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
